// File: rtl/axi_remap_ctrl.sv
//==============================================================================
// Module      : axi_remap_ctrl
// Description : AXI4 address-remapping controller. Rewrites AW/AR addresses
//               via a small table of windows, and sequences table updates:
//               new AW/AR are blocked, in-flight transactions drain, the
//               selected rule is written, and traffic resumes.
// Optional    : AXI_REMAP_CTRL_MISS_CNT_EN enables the 16-bit saturating
//               count of unmatched AW/AR handshakes on miss_cnt_o.
// Ports       : clk_i, rst_i (async, active-high)
//               slv_req_i / slv_resp_o : upstream AXI port
//               mst_req_o / mst_resp_i : downstream AXI port (remapped)
//               cfg_valid_i/cfg_ready_o, cfg_idx_i, cfg_en_i, cfg_base_i,
//               cfg_mask_i, cfg_target_i : rule write interface
//               busy_o : controller not in RUN
//               miss_cnt_o : unmatched address count
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package axi_remap_ctrl_pkg;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic [3:0] id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0] id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module axi_remap_ctrl #(
  parameter int unsigned NoRules = 4,
  parameter int unsigned MaxTxns = 8,
  parameter type addr_t = axi_remap_ctrl_pkg::addr_t,
  parameter type req_t  = axi_remap_ctrl_pkg::req_t,
  parameter type resp_t = axi_remap_ctrl_pkg::resp_t,
  localparam int unsigned c_idx_w = (NoRules > 1) ? $clog2(NoRules) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  req_t               slv_req_i,
  output resp_t              slv_resp_o,
  output req_t               mst_req_o,
  input  resp_t              mst_resp_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [c_idx_w-1:0] cfg_idx_i,
  input  logic               cfg_en_i,
  input  addr_t              cfg_base_i,
  input  addr_t              cfg_mask_i,
  input  addr_t              cfg_target_i,
  output logic               busy_o,
  output logic [15:0]        miss_cnt_o
);

  // One spare code above MaxTxns so a same-cycle AR plus atomic AW at
  // MaxTxns-1 cannot wrap the read counter.
  localparam int unsigned          c_cnt_w    = $clog2(MaxTxns + 2);
  localparam logic [c_cnt_w-1:0]   c_max      = c_cnt_w'(MaxTxns);
  localparam logic [c_idx_w:0]     c_no_rules = (c_idx_w + 1)'(NoRules);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [NoRules-1:0]   r_en;
  addr_t                r_base   [NoRules];
  addr_t                r_mask   [NoRules];
  addr_t                r_target [NoRules];
  logic [c_cnt_w-1:0]   r_w_cnt, r_r_cnt, w_w_cnt_nxt, w_r_cnt_nxt;
  logic                 r_aw_pend, r_ar_pend;
  logic [NoRules-1:0]   w_aw_match, w_ar_match;
  addr_t                w_aw_addr, w_ar_addr;
  logic                 w_aw_allow, w_ar_allow;
  logic                 w_mst_aw_valid, w_mst_ar_valid;
  logic                 w_aw_hs, w_ar_hs, w_b_hs, w_r_done, w_aw_atop_hs;
  logic                 w_cfg_idx_ok;

  // Per-rule window match for both address channels
  for (genvar gi = 0; gi < NoRules; gi++) begin : g_rule
    assign w_aw_match[gi] = r_en[gi] &
      ((slv_req_i.aw.addr & r_mask[gi]) == (r_base[gi] & r_mask[gi]));
    assign w_ar_match[gi] = r_en[gi] &
      ((slv_req_i.ar.addr & r_mask[gi]) == (r_base[gi] & r_mask[gi]));
  end

  // Walk from the highest index down so the lowest matching rule wins
  always_comb begin
    w_aw_addr = slv_req_i.aw.addr;
    w_ar_addr = slv_req_i.ar.addr;
    for (int i = int'(NoRules) - 1; i >= 0; i--) begin
      if (w_aw_match[i]) begin
        w_aw_addr = (r_target[i] & r_mask[i]) | (slv_req_i.aw.addr & ~r_mask[i]);
      end
      if (w_ar_match[i]) begin
        w_ar_addr = (r_target[i] & r_mask[i]) | (slv_req_i.ar.addr & ~r_mask[i]);
      end
    end
  end

  // The pend flags keep an already presented valid alive through a drain
  assign w_aw_allow = ((r_w_cnt < c_max) &&
                       (!slv_req_i.aw.atop[5] || (r_r_cnt < c_max)) &&
                       (r_state == ST_RUN)) || r_aw_pend;
  assign w_ar_allow = ((r_r_cnt < c_max) && (r_state == ST_RUN)) || r_ar_pend;

  assign w_mst_aw_valid = slv_req_i.aw_valid & w_aw_allow;
  assign w_mst_ar_valid = slv_req_i.ar_valid & w_ar_allow;

  always_comb begin
    mst_req_o             = slv_req_i;
    mst_req_o.aw.addr     = w_aw_addr;
    mst_req_o.ar.addr     = w_ar_addr;
    mst_req_o.aw_valid    = w_mst_aw_valid;
    mst_req_o.ar_valid    = w_mst_ar_valid;
    slv_resp_o            = mst_resp_i;
    slv_resp_o.aw_ready   = mst_resp_i.aw_ready & w_aw_allow;
    slv_resp_o.ar_ready   = mst_resp_i.ar_ready & w_ar_allow;
  end

  assign w_aw_hs      = w_mst_aw_valid & mst_resp_i.aw_ready;
  assign w_ar_hs      = w_mst_ar_valid & mst_resp_i.ar_ready;
  assign w_b_hs       = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign w_r_done     = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign w_aw_atop_hs = w_aw_hs & slv_req_i.aw.atop[5];

  // Atomic AWs also produce read data, so they occupy a read slot
  assign w_w_cnt_nxt = r_w_cnt + c_cnt_w'(w_aw_hs) - c_cnt_w'(w_b_hs);
  assign w_r_cnt_nxt = r_r_cnt + c_cnt_w'(w_ar_hs) + c_cnt_w'(w_aw_atop_hs)
                       - c_cnt_w'(w_r_done);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_w_cnt   <= '0;
      r_r_cnt   <= '0;
      r_aw_pend <= 1'b0;
      r_ar_pend <= 1'b0;
    end else begin
      r_w_cnt   <= w_w_cnt_nxt;
      r_r_cnt   <= w_r_cnt_nxt;
      r_aw_pend <= w_mst_aw_valid & ~mst_resp_i.aw_ready;
      r_ar_pend <= w_mst_ar_valid & ~mst_resp_i.ar_ready;
    end
  end

  // Reconfiguration sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready_o = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (cfg_valid_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_w_cnt == '0) && (r_r_cnt == '0) && !r_aw_pend && !r_ar_pend) begin
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        cfg_ready_o = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign busy_o = (r_state != ST_RUN);

  // Out-of-range indices are acknowledged but leave the table untouched
  assign w_cfg_idx_ok = ({1'b0, cfg_idx_i} < c_no_rules);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en <= '0;
      for (int i = 0; i < int'(NoRules); i++) begin
        r_base[i]   <= '0;
        r_mask[i]   <= '0;
        r_target[i] <= '0;
      end
    end else if ((r_state == ST_UPDATE) && w_cfg_idx_ok) begin
      r_en[cfg_idx_i]     <= cfg_en_i;
      r_base[cfg_idx_i]   <= cfg_base_i;
      r_mask[cfg_idx_i]   <= cfg_mask_i;
      r_target[cfg_idx_i] <= cfg_target_i;
    end
  end

`ifdef AXI_REMAP_CTRL_MISS_CNT_EN
  logic [15:0] r_miss_cnt;
  logic [16:0] w_miss_sum;
  logic        w_aw_miss, w_ar_miss;

  assign w_aw_miss  = w_aw_hs & ~(|w_aw_match);
  assign w_ar_miss  = w_ar_hs & ~(|w_ar_match);
  assign w_miss_sum = {1'b0, r_miss_cnt} + 17'(w_aw_miss) + 17'(w_ar_miss);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_miss_cnt <= '0;
    end else if (r_state == ST_UPDATE) begin
      r_miss_cnt <= '0;
    end else if (w_miss_sum[16]) begin
      r_miss_cnt <= 16'hFFFF;
    end else begin
      r_miss_cnt <= w_miss_sum[15:0];
    end
  end

  assign miss_cnt_o = r_miss_cnt;
`else
  assign miss_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_remap_ctrl.sv
//==============================================================================
// Module      : tb_axi_remap_ctrl
// Description : Directed self-checking bench for axi_remap_ctrl. Instance
//               u_dut uses defaults (4 rules, 8 txns); u_lim uses 3 rules and
//               2 txns for the outstanding-limit and invalid-index cases.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi_remap_ctrl;
  import axi_remap_ctrl_pkg::*;

`ifdef AXI_REMAP_CTRL_MISS_CNT_EN
  localparam logic [31:0] c_exp_miss = 32'd1;
`else
  localparam logic [31:0] c_exp_miss = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  req_t        req_a, mreq_a, req_b, mreq_b;
  resp_t       mresp_a, sresp_a, mresp_b, sresp_b;
  logic        cfg_valid_a, cfg_valid_b, rdy_a, rdy_b, busy_a, busy_b;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  addr_t       cfg_base, cfg_mask, cfg_target;
  logic [15:0] miss_a, miss_b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axi_remap_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(req_a), .slv_resp_o(sresp_a),
    .mst_req_o(mreq_a), .mst_resp_i(mresp_a),
    .cfg_valid_i(cfg_valid_a), .cfg_ready_o(rdy_a), .cfg_idx_i(cfg_idx),
    .cfg_en_i(cfg_en), .cfg_base_i(cfg_base), .cfg_mask_i(cfg_mask),
    .cfg_target_i(cfg_target), .busy_o(busy_a), .miss_cnt_o(miss_a)
  );

  axi_remap_ctrl #(.NoRules(3), .MaxTxns(2)) u_lim (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(req_b), .slv_resp_o(sresp_b),
    .mst_req_o(mreq_b), .mst_resp_i(mresp_b),
    .cfg_valid_i(cfg_valid_b), .cfg_ready_o(rdy_b), .cfg_idx_i(cfg_idx),
    .cfg_en_i(cfg_en), .cfg_base_i(cfg_base), .cfg_mask_i(cfg_mask),
    .cfg_target_i(cfg_target), .busy_o(busy_b), .miss_cnt_o(miss_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input bit lim, input logic [1:0] idx, input logic en,
                        input addr_t base, input addr_t mask, input addr_t tgt);
    bit seen;
    cfg_idx = idx; cfg_en = en; cfg_base = base; cfg_mask = mask; cfg_target = tgt;
    if (lim) cfg_valid_b = 1'b1; else cfg_valid_a = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = lim ? rdy_b : rdy_a;
      tick();
    end
    cfg_valid_a = 1'b0;
    cfg_valid_b = 1'b0;
    check("cfg_accept", 32'(seen), 32'd1);
  endtask

  task automatic ar_txn_a(input addr_t addr);
    req_a.ar.addr = addr; req_a.ar_valid = 1'b1; mresp_a.ar_ready = 1'b1;
    tick();
    req_a.ar_valid = 1'b0; mresp_a.ar_ready = 1'b0;
    mresp_a.r_valid = 1'b1; mresp_a.r.last = 1'b1; req_a.r_ready = 1'b1;
    tick();
    mresp_a.r_valid = 1'b0; mresp_a.r.last = 1'b0; req_a.r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_a = '0; mresp_a = '0; req_b = '0; mresp_b = '0;
    cfg_valid_a = 1'b0; cfg_valid_b = 1'b0;
    cfg_idx = '0; cfg_en = 1'b0; cfg_base = '0; cfg_mask = '0; cfg_target = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and identity pass-through
    req_a.ar.addr = 32'h1234_5678; req_a.aw.id = 4'd5; req_a.ar_valid = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_cfg_ready", 32'(rdy_a), 32'd0);
    check("rst_miss", 32'(miss_a), 32'd0);
    check("rst_ar_identity", mreq_a.ar.addr, 32'h1234_5678);
    check("rst_aw_id_pass", 32'(mreq_a.aw.id), 32'd5);
    check("rst_ar_valid_pass", 32'(mreq_a.ar_valid), 32'd1);
    req_a.ar_valid = 1'b0;

    // Config latency on an idle bus: DRAIN in cycle 1, UPDATE in cycle 2
    tick();
    cfg_idx = 2'd0; cfg_en = 1'b1; cfg_base = 32'h1000_0000;
    cfg_mask = 32'hF000_0000; cfg_target = 32'h8000_0000; cfg_valid_a = 1'b1;
    @(negedge clk);
    check("lat_c0_busy", 32'(busy_a), 32'd0);
    tick(); @(negedge clk);
    check("lat_c1_busy", 32'(busy_a), 32'd1);
    check("lat_c1_ready", 32'(rdy_a), 32'd0);
    tick(); @(negedge clk);
    check("lat_c2_ready", 32'(rdy_a), 32'd1);
    tick(); cfg_valid_a = 1'b0;
    @(negedge clk);
    check("lat_c3_busy", 32'(busy_a), 32'd0);
    check("remap_hit", mreq_a.ar.addr, 32'h8234_5678);
    req_a.ar.addr = 32'h2000_0000;
    #1 check("remap_miss", mreq_a.ar.addr, 32'h2000_0000);
    tick();
    ar_txn_a(32'h1234_5678);
    ar_txn_a(32'h2000_0000);
    @(negedge clk);
    check("miss_count", 32'(miss_a), c_exp_miss);

    // Priority: lowest index wins
    do_cfg(1'b0, 2'd0, 1'b1, 32'h1000_0000, 32'hFFFF_0000, 32'hA000_0000);
    @(negedge clk);
    check("miss_clear", 32'(miss_a), 32'd0);
    do_cfg(1'b0, 2'd1, 1'b1, 32'h1000_0000, 32'hF000_0000, 32'hB000_0000);
    req_a.ar.addr = 32'h1000_1234; req_a.aw.addr = 32'h1000_1234;
    @(negedge clk);
    check("prio_ar", mreq_a.ar.addr, 32'hA000_1234);
    check("prio_aw", mreq_a.aw.addr, 32'hA000_1234);
    req_a.ar.addr = 32'h1001_1234;
    #1 check("prio_rule1", mreq_a.ar.addr, 32'hB001_1234);

    // Drain: three writes outstanding, then reconfigure
    tick();
    req_a.aw.addr = 32'h1000_1000; req_a.aw_valid = 1'b1; mresp_a.aw_ready = 1'b1;
    repeat (3) tick();
    req_a.aw_valid = 1'b0;
    cfg_idx = 2'd0; cfg_en = 1'b1; cfg_base = 32'h1000_0000;
    cfg_mask = 32'hF000_0000; cfg_target = 32'hC000_0000; cfg_valid_a = 1'b1;
    tick();
    req_a.aw.addr = 32'h1000_0010; req_a.aw_valid = 1'b1;
    @(negedge clk);
    check("drain_aw_blocked", 32'(mreq_a.aw_valid), 32'd0);
    check("drain_aw_ready", 32'(sresp_a.aw_ready), 32'd0);
    check("drain_busy", 32'(busy_a), 32'd1);
    tick();
    mresp_a.b_valid = 1'b1; req_a.b_ready = 1'b1;
    repeat (3) tick();
    mresp_a.b_valid = 1'b0;
    @(negedge clk);
    check("drain_not_yet", 32'(rdy_a), 32'd0);
    tick(); @(negedge clk);
    check("drain_ready", 32'(rdy_a), 32'd1);
    tick(); cfg_valid_a = 1'b0;
    @(negedge clk);
    check("drain_aw_resume", 32'(mreq_a.aw_valid), 32'd1);
    check("drain_new_rule", mreq_a.aw.addr, 32'hC000_0010);
    tick(); req_a.aw_valid = 1'b0; mresp_a.aw_ready = 1'b0;
    mresp_a.b_valid = 1'b1;
    tick(); mresp_a.b_valid = 1'b0;

    // Pending valid survives into DRAIN
    req_a.aw.addr = 32'h3000_0000; req_a.aw_valid = 1'b1;
    tick();
    cfg_idx = 2'd1; cfg_en = 1'b0; cfg_valid_a = 1'b1;
    tick(); @(negedge clk);
    check("pend_hold", 32'(mreq_a.aw_valid), 32'd1);
    check("pend_busy", 32'(busy_a), 32'd1);
    tick(); @(negedge clk);
    check("pend_hold2", 32'(mreq_a.aw_valid), 32'd1);
    check("pend_ready0", 32'(rdy_a), 32'd0);
    mresp_a.aw_ready = 1'b1;
    tick();
    req_a.aw_valid = 1'b0; mresp_a.aw_ready = 1'b0;
    @(negedge clk);
    check("pend_wait_b", 32'(rdy_a), 32'd0);
    tick(); @(negedge clk);
    check("pend_wait_b2", 32'(rdy_a), 32'd0);
    mresp_a.b_valid = 1'b1;
    tick(); mresp_a.b_valid = 1'b0;
    @(negedge clk);
    check("pend_after_b", 32'(rdy_a), 32'd0);
    tick(); @(negedge clk);
    check("pend_cfg_ready", 32'(rdy_a), 32'd1);
    tick(); cfg_valid_a = 1'b0;

    // Outstanding limit (MaxTxns = 2)
    req_b.ar.addr = 32'h0000_0040; req_b.ar_valid = 1'b1; mresp_b.ar_ready = 1'b1;
    tick(); @(negedge clk);
    check("lim_second_ok", 32'(mreq_b.ar_valid), 32'd1);
    tick(); @(negedge clk);
    check("lim_third_blocked", 32'(mreq_b.ar_valid), 32'd0);
    check("lim_third_ready", 32'(sresp_b.ar_ready), 32'd0);
    req_b.aw.atop = 6'h20; req_b.aw_valid = 1'b1;
    #1 check("lim_atop_blocked", 32'(mreq_b.aw_valid), 32'd0);
    req_b.aw.atop = 6'h00;
    #1 check("lim_plain_aw_ok", 32'(mreq_b.aw_valid), 32'd1);
    req_b.aw_valid = 1'b0;
    mresp_b.r_valid = 1'b1; mresp_b.r.last = 1'b1; req_b.r_ready = 1'b1;
    #1 check("lim_same_cycle", 32'(mreq_b.ar_valid), 32'd0);
    tick(); mresp_b.r_valid = 1'b0;
    @(negedge clk);
    check("lim_release", 32'(mreq_b.ar_valid), 32'd1);
    tick(); req_b.ar_valid = 1'b0; mresp_b.ar_ready = 1'b0;
    mresp_b.r_valid = 1'b1;
    repeat (2) tick();
    mresp_b.r_valid = 1'b0; req_b.r_ready = 1'b0;

    // Invalid index discarded; highest valid index works
    do_cfg(1'b1, 2'd3, 1'b1, 32'h1000_0000, 32'hF000_0000, 32'h9000_0000);
    req_b.ar.addr = 32'h1000_0000;
    @(negedge clk);
    check("bad_idx_ignored", mreq_b.ar.addr, 32'h1000_0000);
    do_cfg(1'b1, 2'd2, 1'b1, 32'h1000_0000, 32'hF000_0000, 32'h9000_0000);
    @(negedge clk);
    check("top_idx_applied", mreq_b.ar.addr, 32'h9000_0000);

    // Reset in DRAIN
    tick();
    req_a.aw.addr = 32'h1000_1234; req_a.ar.addr = 32'h1000_1234;
    req_a.aw_valid = 1'b1; mresp_a.aw_ready = 1'b1;
    tick(); req_a.aw_valid = 1'b0; mresp_a.aw_ready = 1'b0;
    cfg_valid_a = 1'b1;
    tick(); @(negedge clk);
    check("rd_busy_before", 32'(busy_a), 32'd1);
    #2 rst = 1'b1;
    #1 check("rd_busy_async", 32'(busy_a), 32'd0);
    cfg_valid_a = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rd_busy_after", 32'(busy_a), 32'd0);
    check("rd_aw_identity", mreq_a.aw.addr, 32'h1000_1234);
    check("rd_ar_identity", mreq_a.ar.addr, 32'h1000_1234);
    tick(); @(negedge clk);
    check("rd_cfg_dropped", 32'(busy_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
